// File: rtl/controle_elevador_n_andares.sv
// Elevator core for N floors: pending-call register, SCAN service order,
// tick-gated travel/door timers and a passenger counter with capacity alert.
module controle_elevador_n_andares #(
  parameter int NUM_ANDARES   = 4,
  parameter int LARG_ANDAR    = 2,
  parameter int CICLOS_VIAGEM = 8,
  parameter int CICLOS_PORTA  = 10,
  parameter int CAPACIDADE    = 3,
  parameter int LARG_PESSOAS  = 2
) (
  input  logic                    clock_in,
  input  logic                    reset_n,
  input  logic                    tick,
  input  logic                    chamada_valida,
  input  logic [LARG_ANDAR-1:0]   chamada_andar,
  input  logic                    pessoa_entra,
  input  logic                    pessoa_sai,
  output logic [LARG_ANDAR-1:0]   andar_atual,
  output logic                    subindo,
  output logic                    descendo,
  output logic                    parado,
  output logic                    porta_aberta,
  output logic                    porta_fechada,
  output logic [LARG_PESSOAS-1:0] quantidade_pessoas,
  output logic                    alerta_capacidade,
  output logic [NUM_ANDARES-1:0]  chamadas_pendentes,
  output logic                    chamada_rejeitada,
  output logic [1:0]              estado_dbg
);

  // Handshake: chamada_valida, pessoa_entra and pessoa_sai are single-cycle
  // strobes with no ready; each is consumed on the rising edge it is high.

  localparam int MAX_T  = (CICLOS_VIAGEM > CICLOS_PORTA) ? CICLOS_VIAGEM : CICLOS_PORTA;
  localparam int LARG_T = $clog2(MAX_T + 1);
  localparam logic [LARG_ANDAR:0]   N_EXT   = (LARG_ANDAR+1)'(NUM_ANDARES);
  localparam logic [LARG_ANDAR-1:0] TOPO    = LARG_ANDAR'(NUM_ANDARES - 1);
  localparam logic [LARG_T-1:0]     FIM_VIA = LARG_T'(CICLOS_VIAGEM - 1);
  localparam logic [LARG_T-1:0]     FIM_POR = LARG_T'(CICLOS_PORTA - 1);
  localparam logic [LARG_PESSOAS-1:0] CAP   = LARG_PESSOAS'(CAPACIDADE);

  typedef enum logic [1:0] {OCIOSO, MOVENDO, PORTA_ABERTA} estado_t;

  estado_t                 r_estado, w_estado;
  logic [LARG_ANDAR-1:0]   r_andar, w_andar, w_prox_andar;
  logic                    r_sobe, w_sobe;
  logic [NUM_ANDARES-1:0]  r_pend, w_pend, w_marca, w_limpa;
  logic [LARG_PESSOAS-1:0] r_qtd, w_qtd;
  logic [LARG_T-1:0]       r_timer, w_timer;
  logic                    r_rej, w_rej;
  logic                    w_fora, w_valida, w_mesmo, w_reinicia;

  function automatic logic [NUM_ANDARES-1:0] um_quente(input logic [LARG_ANDAR-1:0] a);
    return NUM_ANDARES'(1) << a;
  endfunction

  // True when some pending call lies strictly beyond floor a in direction sobe.
  function automatic logic ha_frente(input logic [NUM_ANDARES-1:0] p,
                                     input logic [LARG_ANDAR-1:0] a,
                                     input logic sobe);
    logic res;
    res = 1'b0;
    for (int i = 0; i < NUM_ANDARES; i++) begin
      if (p[i] && (sobe ? (i > int'(a)) : (i < int'(a)))) res = 1'b1;
    end
    return res;
  endfunction

  always_comb begin
    w_estado     = r_estado;
    w_andar      = r_andar;
    w_sobe       = r_sobe;
    w_timer      = r_timer;
    w_qtd        = r_qtd;
    w_limpa      = '0;
    w_reinicia   = 1'b0;
    w_fora       = ({1'b0, chamada_andar} >= N_EXT);
    w_valida     = chamada_valida && !w_fora;
    w_rej        = chamada_valida && w_fora;
    w_mesmo      = w_valida && (chamada_andar == r_andar) && (r_estado != MOVENDO);
    w_marca      = (w_valida && !w_mesmo) ? um_quente(chamada_andar) : '0;
    w_prox_andar = r_andar;
    if (r_sobe && r_andar != TOPO)       w_prox_andar = r_andar + 1'b1;
    else if (!r_sobe && r_andar != '0)   w_prox_andar = r_andar - 1'b1;

    case (r_estado)
      OCIOSO: begin
        if (w_mesmo) begin
          w_estado = PORTA_ABERTA;
          w_timer  = '0;
        end else if ((r_pend & um_quente(r_andar)) != '0) begin
          w_limpa  = um_quente(r_andar);
          w_estado = PORTA_ABERTA;
          w_timer  = '0;
        end else if (r_pend != '0) begin
          // Nothing ahead means everything pending is behind: reverse.
          if (!ha_frente(r_pend, r_andar, r_sobe)) w_sobe = !r_sobe;
          w_estado = MOVENDO;
          w_timer  = '0;
        end
      end
      MOVENDO: begin
        if (tick) begin
          if (r_timer == FIM_VIA) begin
            w_andar = w_prox_andar;
            w_timer = '0;
            if ((r_pend & um_quente(w_prox_andar)) != '0) begin
              w_limpa  = um_quente(w_prox_andar);
              w_estado = PORTA_ABERTA;
            end else if (!ha_frente(r_pend, w_prox_andar, r_sobe)) begin
              w_estado = OCIOSO;
            end
          end else begin
            w_timer = r_timer + 1'b1;
          end
        end
      end
      PORTA_ABERTA: begin
        w_reinicia = w_mesmo;
        if (pessoa_entra && pessoa_sai) begin
          w_reinicia = 1'b1;
        end else if (pessoa_entra && r_qtd != CAP) begin
          w_qtd      = r_qtd + 1'b1;
          w_reinicia = 1'b1;
        end else if (pessoa_sai && r_qtd != '0) begin
          w_qtd      = r_qtd - 1'b1;
          w_reinicia = 1'b1;
        end
        if (w_reinicia) begin
          w_timer = '0;
        end else if (tick) begin
          if (r_timer == FIM_POR) begin
            w_estado = OCIOSO;
            w_timer  = '0;
          end else begin
            w_timer = r_timer + 1'b1;
          end
        end
      end
      default: w_estado = OCIOSO;
    endcase

    // A floor being served this edge absorbs a simultaneous call to it.
    w_pend = (r_pend | w_marca) & ~w_limpa;
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_estado <= OCIOSO;
      r_andar  <= '0;
      r_sobe   <= 1'b1;
      r_pend   <= '0;
      r_qtd    <= '0;
      r_timer  <= '0;
      r_rej    <= 1'b0;
    end else begin
      r_estado <= w_estado;
      r_andar  <= w_andar;
      r_sobe   <= w_sobe;
      r_pend   <= w_pend;
      r_qtd    <= w_qtd;
      r_timer  <= w_timer;
      r_rej    <= w_rej;
    end
  end

  assign andar_atual        = r_andar;
  assign subindo            = (r_estado == MOVENDO) && r_sobe;
  assign descendo           = (r_estado == MOVENDO) && !r_sobe;
  assign parado             = (r_estado != MOVENDO);
  assign porta_aberta       = (r_estado == PORTA_ABERTA);
  assign porta_fechada      = (r_estado != PORTA_ABERTA);
  assign quantidade_pessoas = r_qtd;
  assign alerta_capacidade  = (r_qtd == CAP);
  assign chamadas_pendentes = r_pend;
  assign chamada_rejeitada  = r_rej;
  assign estado_dbg         = r_estado;

endmodule

// File: tb/tb_controle_elevador_n_andares.sv
// Bench for the elevator core: a 4-floor and a 3-floor instance share stimulus
// and are compared every cycle against an behavioural model, plus directed literals.
module tb_controle_elevador_n_andares;

  localparam int CV = 8, CP = 10, CAP = 3;
  localparam int M_IDLE = 0, M_MOVE = 1, M_DOOR = 2;

  logic clk = 1'b0;
  logic reset_n;
  logic s_tick, s_cv, s_pe, s_ps;
  logic [1:0] s_ca;

  logic [1:0] d4_andar, d4_qtd, d4_dbg;
  logic       d4_sub, d4_desc, d4_par, d4_pa, d4_pf, d4_alerta, d4_rej;
  logic [3:0] d4_pend;
  logic [1:0] d3_andar, d3_qtd, d3_dbg;
  logic       d3_sub, d3_desc, d3_par, d3_pa, d3_pf, d3_alerta, d3_rej;
  logic [2:0] d3_pend;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 0;
  bit log_en   = 0;
  bit prev_pa  = 0;
  int portas_q[$];

  always #5 clk = ~clk;

  controle_elevador_n_andares dut4 (
    .clock_in(clk), .reset_n(reset_n), .tick(s_tick), .chamada_valida(s_cv),
    .chamada_andar(s_ca), .pessoa_entra(s_pe), .pessoa_sai(s_ps),
    .andar_atual(d4_andar), .subindo(d4_sub), .descendo(d4_desc), .parado(d4_par),
    .porta_aberta(d4_pa), .porta_fechada(d4_pf), .quantidade_pessoas(d4_qtd),
    .alerta_capacidade(d4_alerta), .chamadas_pendentes(d4_pend),
    .chamada_rejeitada(d4_rej), .estado_dbg(d4_dbg)
  );

  controle_elevador_n_andares #(.NUM_ANDARES(3)) dut3 (
    .clock_in(clk), .reset_n(reset_n), .tick(s_tick), .chamada_valida(s_cv),
    .chamada_andar(s_ca), .pessoa_entra(s_pe), .pessoa_sai(s_ps),
    .andar_atual(d3_andar), .subindo(d3_sub), .descendo(d3_desc), .parado(d3_par),
    .porta_aberta(d3_pa), .porta_fechada(d3_pf), .quantidade_pessoas(d3_qtd),
    .alerta_capacidade(d3_alerta), .chamadas_pendentes(d3_pend),
    .chamada_rejeitada(d3_rej), .estado_dbg(d3_dbg)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    int st;
    int andar;
    bit up;
    int pend;
    int qtd;
    int tmr;
    bit rej;
  } mstate_t;

  mstate_t m4, m3;

  function automatic mstate_t rst_state();
    mstate_t r;
    r.st = M_IDLE; r.andar = 0; r.up = 1; r.pend = 0; r.qtd = 0; r.tmr = 0; r.rej = 0;
    return r;
  endfunction

  function automatic bit ahead(int pend, int fl, bit up, int n);
    bit r;
    r = 0;
    for (int i = 0; i < n; i++)
      if (pend[i] && (up ? (i > fl) : (i < fl))) r = 1;
    return r;
  endfunction

  function automatic mstate_t step(mstate_t s, int n, bit tk, bit cv, int ca, bit pe, bit ps);
    mstate_t r;
    bit ok, same, restart;
    int add, clr, nf;
    r = s;
    ok = cv && (ca < n);
    r.rej = cv && (ca >= n);
    same = ok && (ca == s.andar) && (s.st != M_MOVE);
    add = (ok && !same) ? (1 << ca) : 0;
    clr = 0;
    if (s.st == M_IDLE) begin
      if (same) begin
        r.st = M_DOOR; r.tmr = 0;
      end else if (s.pend[s.andar]) begin
        clr = 1 << s.andar; r.st = M_DOOR; r.tmr = 0;
      end else if (s.pend != 0) begin
        r.up = ahead(s.pend, s.andar, s.up, n) ? s.up : !s.up;
        r.st = M_MOVE; r.tmr = 0;
      end
    end else if (s.st == M_MOVE) begin
      if (tk) begin
        if (s.tmr + 1 == CV) begin
          nf = s.up ? s.andar + 1 : s.andar - 1;
          if (nf < 0) nf = 0;
          if (nf > n - 1) nf = n - 1;
          r.andar = nf; r.tmr = 0;
          if (s.pend[nf]) begin
            clr = 1 << nf; r.st = M_DOOR;
          end else if (!ahead(s.pend, nf, s.up, n)) begin
            r.st = M_IDLE;
          end
        end else begin
          r.tmr = s.tmr + 1;
        end
      end
    end else begin
      restart = same;
      if (pe && ps) restart = 1;
      else if (pe && s.qtd < CAP) begin r.qtd = s.qtd + 1; restart = 1; end
      else if (ps && s.qtd > 0) begin r.qtd = s.qtd - 1; restart = 1; end
      if (restart) r.tmr = 0;
      else if (tk) begin
        if (s.tmr + 1 == CP) begin r.st = M_IDLE; r.tmr = 0; end
        else r.tmr = s.tmr + 1;
      end
    end
    r.pend = (s.pend | add) & ~clr;
    return r;
  endfunction

  function automatic logic [31:0] pack(mstate_t s);
    return {17'b0, 2'(s.andar), (s.st == M_MOVE) && s.up, (s.st == M_MOVE) && !s.up,
            s.st != M_MOVE, s.st == M_DOOR, s.st != M_DOOR, 2'(s.qtd), s.qtd == CAP,
            4'(s.pend), s.rej};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m4 <= rst_state();
      m3 <= rst_state();
    end else begin
      m4 <= step(m4, 4, s_tick, s_cv, int'(s_ca), s_pe, s_ps);
      m3 <= step(m3, 3, s_tick, s_cv, int'(s_ca), s_pe, s_ps);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  wire [31:0] act4 = {17'b0, d4_andar, d4_sub, d4_desc, d4_par, d4_pa, d4_pf, d4_qtd,
                      d4_alerta, d4_pend, d4_rej};
  wire [31:0] act3 = {17'b0, d3_andar, d3_sub, d3_desc, d3_par, d3_pa, d3_pf, d3_qtd,
                      d3_alerta, 1'b0, d3_pend, d3_rej};

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_n4", act4, pack(m4));
      check("model_n3", act3, pack(m3));
    end
    if (log_en && d4_pa && !prev_pa) portas_q.push_back(int'(d4_andar));
    prev_pa <= d4_pa;
  end

  // ---------------- drivers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chamar(input int a);
    s_cv = 1'b1;
    s_ca = 2'(a);
    cyc(1);
    s_cv = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int k;
    k = 0;
    while (!(d4_pend == 4'd0 && d4_par && !d4_pa) && k < limit) begin
      cyc(1);
      k++;
    end
    if (k >= limit) check({name, "_timeout"}, 32'(k), 32'(limit - 1));
  endtask

  initial begin
    int k;
    reset_n = 1'b0;
    s_tick = 1'b1; s_cv = 1'b0; s_ca = 2'd0; s_pe = 1'b0; s_ps = 1'b0;
    cyc(2);
    cmp_en = 1;

    // reset values
    check("rst_andar", 32'(d4_andar), 32'd0);
    check("rst_pend", 32'(d4_pend), 32'd0);
    check("rst_flags", {26'b0, d4_par, d4_sub, d4_desc, d4_pa, d4_pf, d4_alerta}, 32'b100010);
    reset_n = 1'b1;
    cyc(1);

    // floor 0 -> 2 with tick every cycle
    chamar(2);
    check("t2_pend_latency", 32'(d4_pend), 32'b0100);
    check("t2_still_parked", 32'(d4_par), 32'd1);
    cyc(1);
    check("t2_subindo_2cyc", 32'(d4_sub), 32'd1);
    cyc(7);
    check("t2_andar0_7ticks", 32'(d4_andar), 32'd0);
    cyc(1);
    check("t2_andar1_8ticks", 32'(d4_andar), 32'd1);
    cyc(8);
    check("t2_andar2_16ticks", 32'(d4_andar), 32'd2);
    check("t2_door_open", {30'b0, d4_pa, d4_pend[2]}, 32'b10);
    cyc(9);
    check("t2_door_9ticks", 32'(d4_pa), 32'd1);
    cyc(1);
    check("t2_idle_10ticks", {30'b0, d4_pa, d4_par}, 32'b01);

    // passengers at floor 2 (same-floor call opens door)
    chamar(2);
    check("t4_door_same_floor", 32'(d4_pa), 32'd1);
    s_pe = 1'b1;
    cyc(4);
    s_pe = 1'b0;
    check("t4_qtd_full", {29'b0, d4_qtd, d4_alerta}, 32'b111);
    s_ps = 1'b1;
    cyc(1);
    s_ps = 1'b0;
    check("t4_qtd_sai", {29'b0, d4_qtd, d4_alerta}, 32'b100);
    s_pe = 1'b1; s_ps = 1'b1;
    cyc(1);
    s_pe = 1'b0; s_ps = 1'b0;
    check("t4_qtd_both", 32'(d4_qtd), 32'd2);
    k = 0;
    while (d4_pa && k < 50) begin
      cyc(1);
      k++;
    end
    check("t4_door_restart_len", 32'(k), 32'd10);

    // reset mid-travel at floor 2
    do_reset();
    chamar(3);
    k = 0;
    while (d4_andar != 2'd2 && k < 200) begin
      cyc(1);
      k++;
    end
    check("t1_reach_floor2", {30'b0, d4_andar}, 32'd2);
    #2 reset_n = 1'b0;
    #1;
    check("t1_async_reset", {26'b0, d4_andar, d4_pend}, 32'd0);
    check("t1_async_flags", {30'b0, d4_par, d4_pf}, 32'b11);
    cyc(1);
    reset_n = 1'b1;
    cyc(1);

    // SCAN order: 3, then 0 and 1 while leaving floor 0
    portas_q.delete();
    log_en = 1;
    chamar(3);
    cyc(1);
    check("t3_moving", 32'(d4_sub), 32'd1);
    chamar(0);
    chamar(1);
    check("t3_pend_all", 32'(d4_pend), 32'b1011);
    wait_idle("t3", 600);
    log_en = 0;
    check("t3_stop_count", 32'(portas_q.size()), 32'd3);
    if (portas_q.size() == 3) begin
      check("t3_stop0", 32'(portas_q[0]), 32'd1);
      check("t3_stop1", 32'(portas_q[1]), 32'd3);
      check("t3_stop2", 32'(portas_q[2]), 32'd0);
    end

    // tick frozen while moving
    chamar(3);
    cyc(1);
    s_tick = 1'b0;
    cyc(3);
    chamar(2);
    cyc(30);
    check("t6_frozen_andar", 32'(d4_andar), 32'd0);
    check("t6_pend_latched", {27'b0, d4_sub, d4_pend}, 32'b11100);
    s_tick = 1'b1;

    // out-of-range call on the 3-floor instance
    do_reset();
    chamar(3);
    check("t5_rej_pulse", {28'b0, d3_rej, d3_pend}, 32'b1000);
    check("t5_n4_accepts", {27'b0, d4_rej, d4_pend}, 32'b01000);
    cyc(1);
    check("t5_rej_one_cycle", 32'(d3_rej), 32'd0);

    // randomized traffic
    for (int i = 0; i < 5000; i++) begin
      s_tick = ($urandom_range(0, 3) != 0);
      s_cv   = ($urandom_range(0, 9) == 0);
      s_ca   = 2'($urandom_range(0, 3));
      s_pe   = ($urandom_range(0, 5) == 0);
      s_ps   = ($urandom_range(0, 7) == 0);
      reset_n = ($urandom_range(0, 1499) != 0);
      cyc(1);
    end
    reset_n = 1'b1;
    s_cv = 1'b0; s_pe = 1'b0; s_ps = 1'b0;
    cyc(2);
    cmp_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
